// File: rtl/alu_exec_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_sequencer_if
// Purpose  : Issue handshake, writeback and debug-read bundle for the sequencer.
// Revision : 1.0
// ============================================================================
interface alu_exec_sequencer_if #(
  parameter int XLEN = 16
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            busy;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [4:0]      dbg_raddr;
  logic [XLEN-1:0] dbg_rdata;

  modport master (
    output instr_valid, instr, dbg_raddr,
    input  instr_ready, busy, wb_valid, wb_rd, wb_data, illegal, dbg_rdata
  );

  modport slave (
    input  instr_valid, instr, dbg_raddr,
    output instr_ready, busy, wb_valid, wb_rd, wb_data, illegal, dbg_rdata
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_sequencer
// Purpose  : Multi-cycle RV32 R/I-type ALU execute controller owning the regfile.
// Revision : 1.0
// ============================================================================
module alu_exec_sequencer #(
  parameter int XLEN = 16,
  parameter int SHW  = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  alu_exec_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam int CW = $clog2(XLEN + 1);

  logic [2:0]      r_state, w_state_nxt;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_regs [32];
  logic [XLEN-1:0] r_a, r_b, r_result, r_mcand, r_mplier, r_acc;
  logic [3:0]      r_op;
  logic            r_illegal;
  logic [4:0]      r_wb_rd;
  logic [CW-1:0]   r_cnt;

  logic [6:0]      w_opcode, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_alu, w_acc_nxt;
  logic [3:0]      w_dec_op, w_f3_op;
  logic            w_dec_ill, w_dec_imm, w_accept, w_mul_last;
  logic [SHW-1:0]  w_shamt;

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7     = r_instr[31:25];

  generate
    if (XLEN > 12) begin : g_imm_ext
      assign w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    end else begin : g_imm_trunc
      assign w_imm = r_instr[20 +: XLEN];
    end
  endgenerate

  assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_shamt    = r_b[SHW-1:0];
  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == CW'(1));
  assign w_accept   = bus.instr_valid && (r_state == S_IDLE);

  // funct3 alone selects the op for every encoding without a funct7 variant
  always_comb begin
    w_f3_op = OP_ADD;
    case (w_f3)
      3'b000:  w_f3_op = OP_ADD;
      3'b001:  w_f3_op = OP_SLL;
      3'b010:  w_f3_op = OP_SLT;
      3'b011:  w_f3_op = OP_SLTU;
      3'b100:  w_f3_op = OP_XOR;
      3'b101:  w_f3_op = OP_SRL;
      3'b110:  w_f3_op = OP_OR;
      default: w_f3_op = OP_AND;
    endcase
  end

  always_comb begin
    w_dec_op  = OP_ADD;
    w_dec_ill = 1'b1;
    w_dec_imm = 1'b0;
    if (w_opcode == 7'b0110011) begin
      case (w_f3)
        3'b000: begin
          if (w_f7 == 7'b0000000)      begin w_dec_op = OP_ADD; w_dec_ill = 1'b0; end
          else if (w_f7 == 7'b0100000) begin w_dec_op = OP_SUB; w_dec_ill = 1'b0; end
          else if (w_f7 == 7'b0000001) begin w_dec_op = OP_MUL; w_dec_ill = 1'b0; end
        end
        3'b101: begin
          if (w_f7 == 7'b0000000)      begin w_dec_op = OP_SRL; w_dec_ill = 1'b0; end
          else if (w_f7 == 7'b0100000) begin w_dec_op = OP_SRA; w_dec_ill = 1'b0; end
        end
        default: if (w_f7 == 7'b0000000) begin w_dec_op = w_f3_op; w_dec_ill = 1'b0; end
      endcase
    end else if (w_opcode == 7'b0010011) begin
      w_dec_imm = 1'b1;
      case (w_f3)
        3'b001: if (w_f7 == 7'b0000000) begin w_dec_op = OP_SLL; w_dec_ill = 1'b0; end
        3'b101: begin
          if (w_f7 == 7'b0000000)      begin w_dec_op = OP_SRL; w_dec_ill = 1'b0; end
          else if (w_f7 == 7'b0100000) begin w_dec_op = OP_SRA; w_dec_ill = 1'b0; end
        end
        default: begin w_dec_op = w_f3_op; w_dec_ill = 1'b0; end
      endcase
    end
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_SLL:  w_alu = r_a << w_shamt;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (r_a < r_b)};
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SRL:  w_alu = r_a >> w_shamt;
      OP_SRA:  w_alu = XLEN'($signed(r_a) >>> w_shamt);
      OP_OR:   w_alu = r_a | r_b;
      OP_AND:  w_alu = r_a & r_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_illegal)           w_state_nxt = S_IDLE;
        else if (r_op == OP_MUL) w_state_nxt = S_MUL;
        else                     w_state_nxt = S_WB;
      end
      S_MUL:    if (w_mul_last) w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = rst_n && (r_state == S_IDLE);
    bus.busy        = (r_state != S_IDLE);
    bus.wb_valid    = (r_state == S_WB);
    bus.illegal     = (r_state == S_EXEC) && r_illegal;
  end

  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_result;
  assign bus.dbg_rdata = (bus.dbg_raddr == 5'd0) ? '0 : r_regs[bus.dbg_raddr];

  // wb_rd/wb_data are loaded only on the way into WB so they hold afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_instr   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_wb_rd   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) r_instr <= bus.instr;
        S_DECODE: begin
          r_a       <= w_rs1_val;
          r_b       <= w_dec_imm ? w_imm : w_rs2_val;
          r_op      <= w_dec_op;
          r_illegal <= w_dec_ill;
        end
        S_EXEC: begin
          if (!r_illegal) begin
            if (r_op == OP_MUL) begin
              r_mcand  <= r_a;
              r_mplier <= r_b;
              r_acc    <= '0;
              r_cnt    <= CW'(XLEN);
            end else begin
              r_result <= w_alu;
              r_wb_rd  <= w_rd;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_mul_last) begin
            r_result <= w_acc_nxt;
            r_wb_rd  <= w_rd;
          end
        end
        S_WB: if (r_wb_rd != 5'd0) r_regs[r_wb_rd] <= r_result;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_sequencer
// Purpose  : Scoreboard bench for alu_exec_sequencer (XLEN=16).
// Revision : 1.0
// ============================================================================
module tb_alu_exec_sequencer;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [20:0] sb_q [$];

  alu_exec_sequencer_if #(.XLEN(16)) bus ();

  alu_exec_sequencer #(.XLEN(16), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  always @(negedge clk) begin
    if (bus.wb_valid) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        logic [20:0] e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e[20:16]});
        chk("wb_data", {16'd0, bus.wb_data}, {16'd0, e[15:0]});
      end
    end
  end

  // Starts and ends on an IDLE-cycle negedge; lat = cycles from accept to WB/illegal
  task automatic run(input string tag, input logic [31:0] ins, input bit ill,
                     input logic [4:0] rd, input logic [15:0] data, input int lat,
                     input bit hold);
    int cyc;
    int busy_cyc;
    chk({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    if (!ill) sb_q.push_back({rd, data});
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    cyc = 0;
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.busy && !bus.instr_ready) busy_cyc++;
      if (bus.wb_valid || bus.illegal) break;
      if (cyc > 60) begin
        chk({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    bus.instr_valid = 1'b0;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_busy"}, busy_cyc, lat);
    if (ill) chk({tag, "_no_wb"}, {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, bus.instr_ready}, 32'd1);
    if (!ill) chk({tag, "_hold"}, {16'd0, bus.wb_data}, {16'd0, data});
  endtask

  task automatic dbg(input logic [4:0] a, input logic [15:0] exp);
    bus.dbg_raddr = a;
    #1;
    chk($sformatf("dbg_x%0d", a), {16'd0, bus.dbg_rdata}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_raddr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_out", {11'd0, bus.wb_rd, bus.wb_data}, 32'd0);
    rst_n = 1'b1;
    #1;

    run("addi1", 32'h00500093, 0, 5'd1, 16'h0005, 3, 0);
    run("addi2", 32'hFFD00113, 0, 5'd2, 16'hFFFD, 3, 0);
    dbg(5'd2, 16'hFFFD);
    run("add",  rtype(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 0, 5'd3, 16'h0002, 3, 0);
    run("sub",  rtype(7'h20, 3'b000, 5'd3, 5'd1, 5'd2), 0, 5'd3, 16'h0008, 3, 0);
    run("slt",  rtype(7'h00, 3'b010, 5'd6, 5'd2, 5'd1), 0, 5'd6, 16'h0001, 3, 0);
    run("sltu", rtype(7'h00, 3'b011, 5'd6, 5'd2, 5'd1), 0, 5'd6, 16'h0000, 3, 0);
    run("mul",  32'h02208233, 0, 5'd4, 16'hFFF1, 19, 1);
    dbg(5'd4, 16'hFFF1);
    run("sra",  rtype(7'h20, 3'b101, 5'd5, 5'd2, 5'd1), 0, 5'd5, 16'hFFFF, 3, 0);
    run("srl",  rtype(7'h00, 3'b101, 5'd5, 5'd2, 5'd1), 0, 5'd5, 16'h07FF, 3, 0);
    run("slli", itype(12'd17, 3'b001, 5'd7, 5'd1), 0, 5'd7, 16'h000A, 3, 0);
    run("sll",  rtype(7'h00, 3'b001, 5'd10, 5'd1, 5'd1), 0, 5'd10, 16'h00A0, 3, 0);
    run("srai", itype(12'h402, 3'b101, 5'd9, 5'd2), 0, 5'd9, 16'hFFFF, 3, 0);
    run("xori", itype(12'hFFF, 3'b100, 5'd8, 5'd1), 0, 5'd8, 16'hFFFA, 3, 0);
    run("andi", itype(12'h0F0, 3'b111, 5'd8, 5'd2), 0, 5'd8, 16'h00F0, 3, 0);
    run("sltiu", itype(12'hFFF, 3'b011, 5'd12, 5'd1), 0, 5'd12, 16'h0001, 3, 0);
    run("raw1", itype(12'd1, 3'b000, 5'd11, 5'd11), 0, 5'd11, 16'h0001, 3, 0);
    run("raw2", itype(12'd1, 3'b000, 5'd11, 5'd11), 0, 5'd11, 16'h0002, 3, 0);
    run("ill_op", 32'h0000007F, 1, 5'd0, 16'h0000, 2, 0);
    run("ill_f7", rtype(7'h02, 3'b000, 5'd3, 5'd1, 5'd2), 1, 5'd0, 16'h0000, 2, 0);
    dbg(5'd3, 16'h0008);
    run("addi_x0", itype(12'd9, 3'b000, 5'd0, 5'd0), 0, 5'd0, 16'h0009, 3, 0);
    dbg(5'd0, 16'h0000);

    // Abort a MUL in its fifth iteration
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h02208233;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("abort_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("abort_ill", {31'd0, bus.illegal}, 32'd0);
    chk("abort_out", {11'd0, bus.wb_rd, bus.wb_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) dbg(5'(i), 16'h0000);
    repeat (25) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
